// File: rtl/fp_addsub_pkg.sv
// Shared types for the single-precision add/sub datapath: operand layout and stage payloads.
package fp_addsub_pkg;

    localparam logic [7:0] EXP_MAX = 8'hFF;
    localparam int         BIAS    = 127;
    localparam int         MANW    = 23;
    localparam int         GRSW    = 3;

    typedef struct packed {
        logic            sign;
        logic [7:0]      exp;
        logic [MANW-1:0] man;
    } fp32_t;

    typedef struct packed {
        logic [31:0]   in1;
        logic [31:0]   in2;
        logic [1:0]    toobig;
        logic          sign_l;
        logic          sign_s;
        logic [7:0]    exp_l;
        logic [MANW:0] mant_l;
        logic [MANW:0] mant_s;
        logic [7:0]    d;
    } s1_t;

    typedef struct packed {
        logic [31:0]           in1;
        logic [31:0]           in2;
        logic [1:0]            toobig;
        logic                  sign_l;
        logic [7:0]            exp_l;
        logic [MANW+GRSW+1:0]  sum;
    } s2_t;

endpackage

// File: rtl/fp_addsub_core_lzc.sv
// Combinational leading-zero counter over the 27-bit aligned sum; all-zero input yields 27.
module fp_lzc27
    import fp_addsub_pkg::*;
(
    input  logic [MANW+GRSW:0] v_i,
    output logic [4:0]         cnt_o
);

    always_comb begin
        cnt_o = 5'd27;
        for (int i = 0; i <= MANW + GRSW; i++) begin
            if (v_i[i]) cnt_o = 5'(MANW + GRSW - i);
        end
    end

endmodule

// File: rtl/fp_addsub_core.sv
// Three-stage single-precision add/sub core (unpack/swap, align/add, normalize/pack) with global stall.
// Build option FPADD_ROUND_EN selects round-to-nearest-even; otherwise G/R/S are truncated.
module fp_addsub_core
    import fp_addsub_pkg::*;
#(
    parameter int unsigned TOOBIG_DIFF = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_in1,
    output logic [31:0] out_in2,
    output logic [31:0] temp_result,
    output logic [1:0]  toobig
);

    function automatic logic [24:0] round_mant(input logic [26:0] m);
        logic [24:0] t;
        t = {1'b0, 24'(m >> GRSW)};
`ifdef FPADD_ROUND_EN
        if (m[2] && (m[1] || m[0] || m[3])) t = t + 25'd1;
`endif
        return t;
    endfunction

    // Mantissa carry-out bumps the exponent; then flush underflow to signed zero, clamp overflow to inf.
    function automatic logic [31:0] pack_result(input logic sign, input logic signed [9:0] e,
                                                input logic [24:0] m);
        logic signed [9:0] ef;
        logic [22:0]       man;
        ef  = m[24] ? e + 10'sd1 : e;
        man = m[24] ? m[23:1] : m[22:0];
        if (ef <= 10'sd0)        return {sign, 31'd0};
        else if (ef >= 10'sd255) return {sign, EXP_MAX, 23'd0};
        else                     return {sign, ef[7:0], man};
    endfunction

    logic en;
    logic vld_p1_q, vld_p2_q, out_valid_q;
    s1_t  s1_d, s1_p1_q;
    s2_t  s2_d, s2_p2_q;
    logic [31:0] out_in1_q, out_in2_q, temp_q;
    logic [1:0]  toobig_q;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // Stage 0 -> 1: unpack, effective B, magnitude swap
    fp32_t a_p0, b_p0, l_p0, s_p0;
    logic  b_big_p0;

    always_comb begin
        a_p0     = in_a;
        b_p0     = {in_b[31] ^ in_sub, in_b[30:0]};
        b_big_p0 = {b_p0.exp, b_p0.man} > {a_p0.exp, a_p0.man};
        l_p0     = b_big_p0 ? b_p0 : a_p0;
        s_p0     = b_big_p0 ? a_p0 : b_p0;
        s1_d.in1    = a_p0;
        s1_d.in2    = b_p0;
        s1_d.sign_l = l_p0.sign;
        s1_d.sign_s = s_p0.sign;
        s1_d.exp_l  = l_p0.exp;
        s1_d.mant_l = (l_p0.exp == 8'd0) ? '0 : {1'b1, l_p0.man};
        s1_d.mant_s = (s_p0.exp == 8'd0) ? '0 : {1'b1, s_p0.man};
        s1_d.d      = l_p0.exp - s_p0.exp;
        s1_d.toobig[1] = b_big_p0;
        s1_d.toobig[0] = (s1_d.d >= 8'(TOOBIG_DIFF)) && (a_p0.exp != 8'd0) && (b_p0.exp != 8'd0)
                         && (a_p0.exp != EXP_MAX) && (b_p0.exp != EXP_MAX);
    end

    // Stage 1 -> 2: align smaller operand with sticky, add or subtract
    logic [26:0] l27_p1, sf_p1, sa_p1;
    logic        sticky_p1;

    always_comb begin
        l27_p1    = {s1_p1_q.mant_l, 3'b000};
        sf_p1     = {s1_p1_q.mant_s, 3'b000};
        sticky_p1 = 1'b0;
        sa_p1     = '0;
        if (s1_p1_q.d >= 8'd27) begin
            sa_p1 = {26'd0, |s1_p1_q.mant_s};
        end else begin
            sticky_p1 = |(sf_p1 & ~(27'h7FF_FFFF << s1_p1_q.d));
            sa_p1     = (sf_p1 >> s1_p1_q.d) | {26'd0, sticky_p1};
        end
        s2_d.in1    = s1_p1_q.in1;
        s2_d.in2    = s1_p1_q.in2;
        s2_d.toobig = s1_p1_q.toobig;
        s2_d.sign_l = s1_p1_q.sign_l;
        s2_d.exp_l  = s1_p1_q.exp_l;
        s2_d.sum    = (s1_p1_q.sign_l == s1_p1_q.sign_s) ? {1'b0, l27_p1} + {1'b0, sa_p1}
                                                         : {1'b0, l27_p1} - {1'b0, sa_p1};
    end

    // Stage 2 -> 3: normalize, round, pack
    logic [4:0]        lzc_p2;
    logic [26:0]       norm_p2;
    logic signed [9:0] exp_p2;
    logic [24:0]       rnd_p2;
    logic [31:0]       res_p2;

    fp_lzc27 u_lzc (
        .v_i   (s2_p2_q.sum[26:0]),
        .cnt_o (lzc_p2)
    );

    always_comb begin
        norm_p2 = s2_p2_q.sum[26:0] << lzc_p2;
        exp_p2  = $signed({2'b00, s2_p2_q.exp_l}) - $signed({5'd0, lzc_p2});
        if (s2_p2_q.sum[27]) begin
            norm_p2 = {s2_p2_q.sum[27:2], |s2_p2_q.sum[1:0]};
            exp_p2  = $signed({2'b00, s2_p2_q.exp_l}) + 10'sd1;
        end
        rnd_p2 = round_mant(norm_p2);
        res_p2 = (s2_p2_q.sum == '0) ? 32'h0 : pack_result(s2_p2_q.sign_l, exp_p2, rnd_p2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            vld_p1_q    <= in_valid;
            vld_p2_q    <= vld_p1_q;
            out_valid_q <= vld_p2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_p1_q <= s1_d;
            s2_p2_q <= s2_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_in1_q <= '0;
            out_in2_q <= '0;
            temp_q    <= '0;
            toobig_q  <= '0;
        end else if (en && vld_p2_q) begin
            out_in1_q <= s2_p2_q.in1;
            out_in2_q <= s2_p2_q.in2;
            temp_q    <= res_p2;
            toobig_q  <= s2_p2_q.toobig;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_in1     = out_in1_q;
    assign out_in2     = out_in2_q;
    assign temp_result = temp_q;
    assign toobig      = toobig_q;

endmodule

// File: tb/tb_fp_addsub_core.sv
// Bench for fp_addsub_core: directed cases, stall/reset scenarios and randomized traffic against a real-arithmetic model.
module tb_fp_addsub_core;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] temp;
        logic [1:0]  tb;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_in1, out_in2, temp_result;
    logic [1:0]  toobig;

    int   n_chk  = 0;
    int   n_fail = 0;
    txn_t exp_q[$];
    txn_t mon_e;
    bit   done;
    logic [31:0] ra, rb;
    int   ea, eb;

    fp_addsub_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_sub      (in_sub),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_in1     (out_in1),
        .out_in2     (out_in2),
        .temp_result (temp_result),
        .toobig      (toobig)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Converts an exactly representable double to single with flush-to-zero and overflow to inf.
    function automatic logic [31:0] r2f(input real x);
        logic [63:0] d;
        logic [52:0] m;
        logic [24:0] k;
        int          e;
`ifdef FPADD_ROUND_EN
        logic [28:0] rest;
`endif
        d = $realtobits(x);
        if (d[62:0] == 63'd0) return 32'h0;
        e = int'(d[62:52]) - 1023 + 127;
        m = {1'b1, d[51:0]};
        k = {1'b0, m[52:29]};
`ifdef FPADD_ROUND_EN
        rest = m[28:0];
        if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && k[0])) k = k + 25'd1;
`endif
        if (k[24]) begin
            e = e + 1;
            k = k >> 1;
        end
        if (e <= 0)   return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], 8'(e), k[22:0]};
    endfunction

    function automatic txn_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        txn_t       r;
        logic [31:0] be;
        logic [7:0]  xa, xb, dd;
        logic        big;
        be  = {b[31] ^ sub, b[30:0]};
        big = be[30:0] > a[30:0];
        xa  = a[30:23];
        xb  = b[30:23];
        dd  = big ? xb - xa : xa - xb;
        r.in1  = a;
        r.in2  = be;
        r.tb   = {big, (dd >= 8'd26) && xa != 8'd0 && xb != 8'd0 && xa != 8'hFF && xb != 8'hFF};
        r.temp = r2f(f2r(a) + f2r(be));
        return r;
    endfunction

    task automatic send_x(input logic [31:0] a, input logic [31:0] b, input logic s, input txn_t e);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = s;
        #2;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (!in_ready) begin
            chk("send_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
        send_x(a, b, s, model(a, b, s));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_in1", out_in1, mon_e.in1);
                chk("out_in2", out_in2, mon_e.in2);
                chk("temp_result", temp_result, mon_e.temp);
                chk("toobig", {30'd0, toobig}, {30'd0, mon_e.tb});
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_temp", temp_result, 32'h0);
        chk("rst_in1", out_in1, 32'h0);
        chk("rst_in2", out_in2, 32'h0);
        chk("rst_toobig", {30'd0, toobig}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: visible after the third rising edge counting the accepting one
        send_x(32'h3F80_0000, 32'h3F80_0000, 1'b0, '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 2'b00});
        @(negedge clk);
        in_valid = 1'b0;
        #2 chk("lat_edge1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #2 chk("lat_edge2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #2 chk("lat_edge3", {31'd0, out_valid}, 32'd1);
        drain();

        send_x(32'h3F80_0000, 32'h3F80_0000, 1'b1, '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 2'b00});
        send_x(32'h3F80_0000, 32'h3080_0000, 1'b0, '{32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000, 2'b01});
        send_x(32'h3080_0000, 32'h3F80_0000, 1'b0, '{32'h3080_0000, 32'h3F80_0000, 32'h3F80_0000, 2'b11});
        send_x(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 2'b00});
`ifdef FPADD_ROUND_EN
        send_x(32'h3F80_0001, 32'h3380_0000, 1'b0, '{32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 2'b00});
`else
        send_x(32'h3F80_0001, 32'h3380_0000, 1'b0, '{32'h3F80_0001, 32'h3380_0000, 32'h3F80_0001, 2'b00});
`endif
        idle(1);
        drain();

        // Back-pressure: four pairs into a stalled pipeline
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                send(32'h4040_0000, 32'h3F80_0000, 1'b0);
                send(32'h4120_0000, 32'h4000_0000, 1'b1);
                send(32'hC2C8_0000, 32'h4148_0000, 1'b0);
                send(32'h3DCC_CCCD, 32'h3E4C_CCCD, 1'b1);
                idle(1);
            end
            begin
                for (int i = 0; i < 20 && !out_valid; i++) begin
                    @(negedge clk);
                    #2;
                end
                chk("stall_fill", {31'd0, out_valid}, 32'd1);
                repeat (5) begin
                    @(negedge clk);
                    #2;
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall_hold", temp_result, exp_q[0].temp);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Randomized traffic with random back-pressure; exponent gap kept within exact double range
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    ea = int'($urandom_range(1, 254));
                    eb = ea + int'($urandom_range(0, 56)) - 28;
                    if (eb < 1) eb = 1;
                    if (eb > 254) eb = 254;
                    ra = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
                    rb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
                    if ($urandom_range(0, 9) == 0) rb = {1'($urandom_range(0, 1)), ra[30:0]};
                    send(ra, rb, 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 4) == 0) idle(1);
                end
                idle(1);
                drain();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        // Reset while items are in flight
        @(negedge clk);
        out_ready = 1'b1;
        send(32'h4000_0000, 32'h4040_0000, 1'b0);
        send(32'h4080_0000, 32'h3F80_0000, 1'b1);
        send(32'h40A0_0000, 32'h40A0_0000, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_temp", temp_result, 32'h0);
        chk("midrst_in1", out_in1, 32'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #2 chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);
        end
        send(32'h4110_0000, 32'hC000_0000, 1'b1);
        idle(1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
